// File: rtl/m062_dram_timing_ctrl.sv
// DRAM timing sequencer for the M062 RAM module: turns registered Z80 bus strobes into
// RAS/CAS/WE, the row/column address mux, WAIT_N and hidden refresh for a 64K x 1 bank.
module m062_dram_timing_ctrl #(
  parameter int T_RCD = 1,
  parameter int T_CAS = 2,
  parameter int T_RP  = 2,
  parameter int T_RFR = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_mreq_n,
  input  logic        i_wr_n,
  input  logic        i_rfsh_n,
  input  logic        i_sel,
  output logic        o_ras_n,
  output logic        o_cas_n,
  output logic        o_we_n,
  output logic        o_mux,
  output logic [7:0]  o_dram_a,
  output logic        o_wait_n,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAS,
    S_COL,
    S_CAS,
    S_PRE,
    S_RFR
  } state_t;

  localparam logic [7:0] L_RCD = 8'(T_RCD - 1);
  localparam logic [7:0] L_CAS = 8'(T_CAS - 1);
  localparam logic [7:0] L_RP  = 8'(T_RP - 1);
  localparam logic [7:0] L_RFR = 8'(T_RFR - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic [7:0]  r_cnt;
  logic [15:0] r_addr;
  logic        r_mreq_n;
  logic        r_wr_n;
  logic        r_rfsh_n;
  logic        r_sel;
  logic        r_acc_prev;
  logic        r_rfr_prev;
  logic        r_pend_acc;
  logic        r_pend_rfr;
  logic [7:0]  r_rcnt;
  logic        r_ras_n;
  logic        r_cas_n;
  logic        r_we_n;
  logic        r_mux;
  logic [7:0]  r_dram_a;
  logic        r_wait_n;
  logic        r_busy;
  logic        w_acc;
  logic        w_rfr;
  logic        w_acc_go;
  logic        w_rfr_go;
  logic        w_pend_acc_nxt;
  logic        w_pend_rfr_nxt;

  assign w_acc    = r_sel & ~r_mreq_n & r_rfsh_n;
  assign w_rfr    = ~r_mreq_n & ~r_rfsh_n;
  // A request level held from a previous cycle only restarts if it was pended in PRE.
  assign w_acc_go = w_acc & (~r_acc_prev | r_pend_acc);
  assign w_rfr_go = w_rfr & (~r_rfr_prev | r_pend_rfr);

  always_comb begin
    w_nxt          = r_state;
    w_pend_acc_nxt = r_pend_acc;
    w_pend_rfr_nxt = r_pend_rfr;
    case (r_state)
      S_IDLE: begin
        w_pend_acc_nxt = 1'b0;
        w_pend_rfr_nxt = 1'b0;
        if (w_rfr_go)      w_nxt = S_RFR;
        else if (w_acc_go) w_nxt = S_RAS;
      end
      S_RAS: if (r_cnt >= L_RCD) w_nxt = S_COL;
      S_COL: w_nxt = S_CAS;
      S_CAS: if ((r_cnt >= L_CAS) && r_mreq_n) w_nxt = S_PRE;
      S_RFR: if ((r_cnt >= L_RFR) && r_mreq_n) w_nxt = S_PRE;
      S_PRE: begin
        if (w_acc && !r_acc_prev) w_pend_acc_nxt = 1'b1;
        if (w_rfr && !r_rfr_prev) w_pend_rfr_nxt = 1'b1;
        if (r_cnt >= L_RP) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_mreq_n   <= 1'b1;
      r_wr_n     <= 1'b1;
      r_rfsh_n   <= 1'b1;
      r_sel      <= 1'b0;
      r_acc_prev <= 1'b0;
      r_rfr_prev <= 1'b0;
    end else begin
      r_addr     <= i_addr;
      r_mreq_n   <= i_mreq_n;
      r_wr_n     <= i_wr_n;
      r_rfsh_n   <= i_rfsh_n;
      r_sel      <= i_sel;
      r_acc_prev <= w_acc;
      r_rfr_prev <= w_rfr;
    end
  end

  // Outputs are decoded from the next state so every strobe is a flop output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pend_acc <= 1'b0;
      r_pend_rfr <= 1'b0;
      r_rcnt     <= '0;
      r_ras_n    <= 1'b1;
      r_cas_n    <= 1'b1;
      r_we_n     <= 1'b1;
      r_mux      <= 1'b0;
      r_dram_a   <= '0;
      r_wait_n   <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_pend_acc <= w_pend_acc_nxt;
      r_pend_rfr <= w_pend_rfr_nxt;
      if (w_nxt != r_state)    r_cnt <= '0;
      else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      if ((r_state == S_RFR) && (w_nxt == S_PRE)) r_rcnt <= r_rcnt + 8'd1;
      r_ras_n  <= !((w_nxt == S_RAS) || (w_nxt == S_COL) || (w_nxt == S_CAS) || (w_nxt == S_RFR));
      r_cas_n  <= (w_nxt != S_CAS);
      r_we_n   <= (w_nxt == S_CAS) ? r_wr_n : 1'b1;
      r_mux    <= (w_nxt == S_COL) || (w_nxt == S_CAS);
      r_busy   <= (w_nxt != S_IDLE);
      r_wait_n <= !w_pend_acc_nxt;
      case (w_nxt)
        S_RAS:        r_dram_a <= r_addr[7:0];
        S_COL, S_CAS: r_dram_a <= r_addr[15:8];
        S_RFR:        r_dram_a <= r_rcnt;
        default:      r_dram_a <= r_dram_a;
      endcase
    end
  end

  assign o_ras_n  = r_ras_n;
  assign o_cas_n  = r_cas_n;
  assign o_we_n   = r_we_n;
  assign o_mux    = r_mux;
  assign o_dram_a = r_dram_a;
  assign o_wait_n = r_wait_n;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_m062_dram_timing_ctrl.sv
// Bench for m062_dram_timing_ctrl: a per-edge stimulus table is built (directed + random bus
// cycles), expected outputs come from a transaction-level timing model, then compared each cycle.
module tb_m062_dram_timing_ctrl;

  localparam int MAXN  = 8192;
  localparam int T_RCD = 1;
  localparam int T_CAS = 2;
  localparam int T_RP  = 2;
  localparam int T_RFR = 3;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] addr;
  logic        mreqN, wrN, rfshN, sel;
  logic        rasN, casN, weN, mux, waitN, busy;
  logic [7:0]  dramA;

  int checks = 0;
  int errors = 0;
  int N = 0;

  logic [15:0] sAddr [MAXN];
  logic        sMreq [MAXN];
  logic        sWr   [MAXN];
  logic        sRfsh [MAXN];
  logic        sSel  [MAXN];

  logic        eRas  [MAXN];
  logic        eCas  [MAXN];
  logic        eWe   [MAXN];
  logic        eMux  [MAXN];
  logic        eBusy [MAXN];
  logic        eWait [MAXN];
  logic [7:0]  eDa   [MAXN];
  logic        daSet [MAXN];
  logic [7:0]  daVal [MAXN];

  always #5 clk = ~clk;

  m062_dram_timing_ctrl #(.T_RCD(T_RCD), .T_CAS(T_CAS), .T_RP(T_RP), .T_RFR(T_RFR)) dut (
    .i_clk    (clk),
    .i_rst_n  (rstN),
    .i_addr   (addr),
    .i_mreq_n (mreqN),
    .i_wr_n   (wrN),
    .i_rfsh_n (rfshN),
    .i_sel    (sel),
    .o_ras_n  (rasN),
    .o_cas_n  (casN),
    .o_we_n   (weN),
    .o_mux    (mux),
    .o_dram_a (dramA),
    .o_wait_n (waitN),
    .o_busy   (busy)
  );

  function automatic logic accAt(input int k);
    if (k < 0) return 1'b0;
    return sSel[k] & ~sMreq[k] & sRfsh[k];
  endfunction

  function automatic logic rfrAt(input int k);
    if (k < 0) return 1'b0;
    return ~sMreq[k] & ~sRfsh[k];
  endfunction

  function automatic logic mreqAt(input int k);
    if (k < 0) return 1'b1;
    return sMreq[k];
  endfunction

  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++) begin
      sAddr[N] = 16'($urandom);
      sMreq[N] = 1'b1;
      sWr[N]   = 1'b1;
      sRfsh[N] = 1'b1;
      sSel[N]  = 1'($urandom_range(0, 1));
      N++;
    end
  endtask

  // kind: 0 read, 1 write (WR_N falls wrOff cycles into MREQ), 2 refresh
  task automatic addCycle(input int kind, input logic [15:0] a, input int len,
                          input int wrOff, input logic s);
    for (int i = 0; i < len; i++) begin
      sAddr[N] = a;
      sMreq[N] = 1'b0;
      sWr[N]   = (kind == 1 && i >= wrOff) ? 1'b0 : 1'b1;
      sRfsh[N] = (kind == 2) ? 1'b0 : 1'b1;
      sSel[N]  = s;
      N++;
    end
  endtask

  // Transaction-level timing: each bus cycle occupies [start, precharge end) in edge units.
  task automatic buildExpected();
    int e, s, c, p;
    logic pa, pr, goA, goR;
    logic [7:0] rc, da;
    for (int t = 0; t < N; t++) begin
      eRas[t] = 1'b1; eCas[t] = 1'b1; eWe[t] = 1'b1; eMux[t] = 1'b0;
      eBusy[t] = 1'b0; eWait[t] = 1'b1; daSet[t] = 1'b0; daVal[t] = 8'h00;
    end
    e = 0; pa = 1'b0; pr = 1'b0; rc = 8'h00;
    while (e < N) begin
      goR = rfrAt(e - 1) && (!rfrAt(e - 2) || pr);
      goA = accAt(e - 1) && (!accAt(e - 2) || pa);
      pa = 1'b0; pr = 1'b0;
      if (!goR && !goA) begin
        e++;
        continue;
      end
      s = e;
      if (goR) begin
        p = s + T_RFR;
        while (p < N && !mreqAt(p - 1)) p++;
        for (int t = s; t < p && t < N; t++) begin
          eRas[t] = 1'b0; eBusy[t] = 1'b1; daSet[t] = 1'b1; daVal[t] = rc;
        end
        rc = rc + 8'd1;
      end else begin
        c = s + T_RCD + 1;
        p = c + T_CAS;
        while (p < N && !mreqAt(p - 1)) p++;
        for (int t = s; t < p && t < N; t++) begin
          eRas[t] = 1'b0; eBusy[t] = 1'b1; daSet[t] = 1'b1;
          if (t < s + T_RCD) daVal[t] = sAddr[t-1][7:0];
          else begin
            eMux[t] = 1'b1;
            daVal[t] = sAddr[t-1][15:8];
          end
          if (t >= c) begin
            eCas[t] = 1'b0;
            eWe[t]  = sWr[t-1];
          end
        end
      end
      for (int t = p; t < p + T_RP && t < N; t++) eBusy[t] = 1'b1;
      for (int t = p + 1; t <= p + T_RP && t < N; t++) begin
        if (accAt(t - 1) && !accAt(t - 2)) pa = 1'b1;
        if (rfrAt(t - 1) && !rfrAt(t - 2)) pr = 1'b1;
        if (pa) eWait[t] = 1'b0;
      end
      e = p + T_RP + 1;
    end
    da = 8'h00;
    for (int t = 0; t < N; t++) begin
      if (daSet[t]) da = daVal[t];
      eDa[t] = da;
    end
  endtask

  task automatic check1(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic applyStimulus(input int k);
    addr  = sAddr[k];
    mreqN = sMreq[k];
    wrN   = sWr[k];
    rfshN = sRfsh[k];
    sel   = sSel[k];
  endtask

  task automatic checkOutput(input int k);
    check1("ras_n",  k, 8'(rasN),  8'(eRas[k]));
    check1("cas_n",  k, 8'(casN),  8'(eCas[k]));
    check1("we_n",   k, 8'(weN),   8'(eWe[k]));
    check1("mux",    k, 8'(mux),   8'(eMux[k]));
    check1("busy",   k, 8'(busy),  8'(eBusy[k]));
    check1("wait_n", k, 8'(waitN), 8'(eWait[k]));
    check1("dram_a", k, dramA,     eDa[k]);
  endtask

  task automatic driveIdle();
    addr = 16'h0000; mreqN = 1'b1; wrN = 1'b1; rfshN = 1'b1; sel = 1'b0;
  endtask

  initial begin
    int guard;
    int kind, len;
    rstN = 1'b0;
    driveIdle();

    addIdle(3);
    addCycle(0, 16'hA35C, 8, 0, 1'b1);
    addIdle(4);
    addCycle(1, 16'hA35C, 8, 2, 1'b1);
    addIdle(4);
    for (int i = 0; i < 257; i++) begin
      addCycle(2, 16'($urandom), 2, 0, 1'($urandom_range(0, 1)));
      addIdle(3);
    end
    addCycle(0, 16'h1234, 4, 0, 1'b1);
    addIdle(1);
    addCycle(0, 16'hBEEF, 8, 0, 1'b1);
    addIdle(4);
    addCycle(0, 16'h5A5A, 6, 0, 1'b0);
    addIdle(3);
    for (int i = 0; i < 150; i++) begin
      addIdle($urandom_range(1, 4));
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 7);
      addCycle(kind, 16'($urandom), len, $urandom_range(0, len - 1),
               1'($urandom_range(0, 3) != 0));
    end
    addIdle(10);
    buildExpected();

    repeat (3) @(posedge clk);
    #1;
    check1("rst_ras_n",  -1, 8'(rasN),  8'h01);
    check1("rst_cas_n",  -1, 8'(casN),  8'h01);
    check1("rst_we_n",   -1, 8'(weN),   8'h01);
    check1("rst_mux",    -1, 8'(mux),   8'h00);
    check1("rst_busy",   -1, 8'(busy),  8'h00);
    check1("rst_wait_n", -1, 8'(waitN), 8'h01);
    check1("rst_dram_a", -1, dramA,     8'h00);
    @(negedge clk);
    rstN = 1'b1;

    for (int k = 0; k < N; k++) begin
      applyStimulus(k);
      @(posedge clk);
      #1;
      checkOutput(k);
    end

    // Asynchronous reset in the middle of CAS, then refresh counter restarts at 0.
    addr = 16'hC0DE; sel = 1'b1; rfshN = 1'b1; wrN = 1'b1; mreqN = 1'b0;
    guard = 0;
    while (casN !== 1'b0 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check1("cas_reached", guard, 8'(casN), 8'h00);
    #2;
    rstN = 1'b0;
    #1;
    check1("async_ras_n",  0, 8'(rasN),  8'h01);
    check1("async_cas_n",  0, 8'(casN),  8'h01);
    check1("async_we_n",   0, 8'(weN),   8'h01);
    check1("async_mux",    0, 8'(mux),   8'h00);
    check1("async_busy",   0, 8'(busy),  8'h00);
    check1("async_dram_a", 0, dramA,     8'h00);
    driveIdle();
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      #1;
      mreqN = 1'b0; rfshN = 1'b0;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      check1("rfr_ras_n",  r, 8'(rasN), 8'h00);
      check1("rfr_cas_n",  r, 8'(casN), 8'h01);
      check1("rfr_dram_a", r, dramA,    8'(r));
      mreqN = 1'b1; rfshN = 1'b1;
      guard = 0;
      while (busy !== 1'b0 && guard < 20) begin
        @(posedge clk);
        #1;
        guard++;
      end
      check1("rfr_done", r, 8'(busy), 8'h00);
      @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
